prism_shift_fifo: RTL and testbench

Parametrised serial-capture datapath for the PRISM peripheral family. It replaces the fixed 8-bit comm shifter and the 3-byte FIFO carved out of the 24-bit counter with a DATA_W-bit shift register feeding a DEPTH-entry first-word-fall-through FIFO. It adds level reporting, sticky overflow/underflow flags, flush and an optional threshold interrupt. It sits between the PRISM FSM outputs (shift/push strobes) and the host register read path.

---
 rtl/prism_sfifo_pkg.sv | 13 +
 rtl/prism_shift_fifo_if.sv | 44 ++++
 rtl/prism_sfifo_mem.sv | 31 +++
 rtl/prism_shift_fifo.sv | 135 +++++++++++++
 tb/tb_prism_shift_fifo.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/prism_sfifo_pkg.sv
// Shared constants for the PRISM serial-capture FIFO: legal parameter limits
// and the shift_dir encodings.
package prism_sfifo_pkg;

    localparam int DATA_W_MIN = 2;
    localparam int DATA_W_MAX = 32;
    localparam int DEPTH_MIN  = 2;
    localparam int DEPTH_MAX  = 16;

    localparam logic SHIFT_MSB_FIRST = 1'b0;
    localparam logic SHIFT_LSB_FIRST = 1'b1;

endpackage

// File: rtl/prism_shift_fifo_if.sv
// Strobe/status bundle between the PRISM FSM / host register path (master)
// and the shift-FIFO datapath (slave).
interface prism_shift_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BIT_W = $clog2(DATA_W);

    logic              enable;
    logic              shift_en;
    logic              shift_in;
    logic              shift_dir;
    logic              auto_push;
    logic              push;
    logic              rd_req;
    logic              flush;
    logic              clr_err;
    logic [CNT_W-1:0]  thresh;

    logic              shift_out;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;
    logic              irq;

    modport master (
        output enable, shift_en, shift_in, shift_dir, auto_push, push,
               rd_req, flush, clr_err, thresh,
        input  shift_out, bit_cnt, rd_data, level, full, empty,
               overflow, underflow, irq
    );

    modport slave (
        input  enable, shift_en, shift_in, shift_dir, auto_push, push,
               rd_req, flush, clr_err, thresh,
        output shift_out, bit_cnt, rd_data, level, full, empty,
               overflow, underflow, irq
    );
endinterface

// File: rtl/prism_sfifo_mem.sv
// DEPTH x DATA_W flop storage: one write port, asynchronous read port,
// cleared on reset.
module prism_sfifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;

    // Per-entry decode keeps non-power-of-two depths from writing past the array.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                mem_q[i] <= '0;
            else if (we_i && waddr_i == PTR_W'(i))
                mem_q[i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prism_shift_fifo.sv
// PRISM serial-capture datapath: DATA_W shift register feeding a DEPTH-entry
// FWFT FIFO. Define PRISM_SFIFO_THRESH_IRQ_EN to enable the threshold irq.
module prism_shift_fifo
    import prism_sfifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int BIT_W  = $clog2(DATA_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    prism_shift_fifo_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] sr_q, sr_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d, udf_q, udf_d, irq_q, irq_d;

    logic              shift, wrap, full, empty;
    logic              push_req, pop_req, do_push, do_pop;
    logic [DATA_W-1:0] head;

    assign full  = (level_q == CNT_W'(DEPTH));
    assign empty = (level_q == '0);
    assign shift = bus.enable & bus.shift_en;

    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        wrap      = 1'b0;
        if (shift) begin
            sr_d = (bus.shift_dir == SHIFT_LSB_FIRST) ? {bus.shift_in, sr_q[DATA_W-1:1]}
                                                      : {sr_q[DATA_W-2:0], bus.shift_in};
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                bit_cnt_d = '0;
                wrap      = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
        if (bus.flush) begin
            sr_d      = '0;
            bit_cnt_d = '0;
        end
    end

    // flush suppresses push/pop entirely, so it can never raise an error either.
    assign push_req = bus.enable & (bus.push | (bus.auto_push & wrap)) & ~bus.flush;
    assign pop_req  = bus.rd_req & ~bus.flush;
    assign do_pop   = pop_req & ~empty;
    assign do_push  = push_req & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push)
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (do_push && !do_pop)
            level_d = level_q + 1'b1;
        else if (do_pop && !do_push)
            level_d = level_q - 1'b1;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    // Set beats clear when both land in the same cycle.
    assign ovf_d = (push_req & full & ~do_pop) | (ovf_q & ~bus.clr_err);
    assign udf_d = (pop_req & empty) | (udf_q & ~bus.clr_err);

`ifdef PRISM_SFIFO_THRESH_IRQ_EN
    assign irq_d = (bus.thresh != '0) && (level_d >= bus.thresh);
`else
    logic unused_thresh;
    assign unused_thresh = ^bus.thresh;
    assign irq_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            irq_q     <= irq_d;
        end
    end

    prism_sfifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (do_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (sr_d),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign bus.shift_out = (bus.shift_dir == SHIFT_LSB_FIRST) ? sr_q[0] : sr_q[DATA_W-1];
    assign bus.bit_cnt   = bit_cnt_q;
    assign bus.rd_data   = empty ? '0 : head;
    assign bus.level     = level_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
    assign bus.irq       = irq_q;

endmodule

// File: tb/tb_prism_shift_fifo.sv
// Directed bench for prism_shift_fifo: queue-based reference model compared
// every cycle, plus hand-computed literal checkpoints.
module tb_prism_shift_fifo;

    localparam int DW = 8;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   check_en = 1'b0;

    always #5 clk = ~clk;

    prism_shift_fifo_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

    prism_shift_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: word queue plus a shift word and a bit counter.
    int unsigned m_sr;
    int          m_bc;
    int unsigned m_q[$];
    bit          m_ovf, m_udf, m_irq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sr = 0; m_bc = 0; m_q.delete();
            m_ovf = 0; m_udf = 0; m_irq = 0;
        end else begin
            bit wrap, pushr, popr, was_empty, was_full, ovf_set, udf_set;
            wrap = 0; ovf_set = 0; udf_set = 0;
            if (bus.flush) begin
                m_sr = 0; m_bc = 0; m_q.delete();
            end else begin
                if (bus.enable && bus.shift_en) begin
                    if (bus.shift_dir)
                        m_sr = (m_sr >> 1) | (int'(bus.shift_in) << (DW - 1));
                    else
                        m_sr = ((m_sr << 1) | int'(bus.shift_in)) & ((1 << DW) - 1);
                    m_bc++;
                    if (m_bc == DW) begin m_bc = 0; wrap = 1; end
                end
                pushr     = bus.enable && (bus.push || (bus.auto_push && wrap));
                popr      = bus.rd_req;
                was_empty = (m_q.size() == 0);
                was_full  = (m_q.size() == DP);
                udf_set   = popr && was_empty;
                ovf_set   = pushr && was_full && !popr;
                if (popr && !was_empty) void'(m_q.pop_front());
                if (pushr && !ovf_set) m_q.push_back(m_sr);
            end
            m_ovf = ovf_set || (m_ovf && !bus.clr_err);
            m_udf = udf_set || (m_udf && !bus.clr_err);
`ifdef PRISM_SFIFO_THRESH_IRQ_EN
            m_irq = (bus.thresh != 0) && (m_q.size() >= int'(bus.thresh));
`else
            m_irq = 0;
`endif
        end
    end

    always @(negedge clk) begin
        if (check_en && rst_n) begin
            chk("shift_out", bus.shift_out, bus.shift_dir ? m_sr[0] : m_sr[DW-1]);
            chk("bit_cnt",   bus.bit_cnt,   m_bc);
            chk("rd_data",   bus.rd_data,   m_q.size() == 0 ? 0 : m_q[0]);
            chk("level",     bus.level,     m_q.size());
            chk("full",      bus.full,      m_q.size() == DP);
            chk("empty",     bus.empty,     m_q.size() == 0);
            chk("overflow",  bus.overflow,  m_ovf);
            chk("underflow", bus.underflow, m_udf);
            chk("irq",       bus.irq,       m_irq);
        end
    end

    // One clock with the given strobes; returns at negedge+1 with strobes cleared.
    task automatic cyc(input logic sen, input logic sin, input logic psh, input logic rd);
        bus.shift_en = sen;
        bus.shift_in = sin;
        bus.push     = psh;
        bus.rd_req   = rd;
        @(negedge clk); #1;
        bus.shift_en = 0; bus.shift_in = 0; bus.push = 0; bus.rd_req = 0;
        bus.flush = 0; bus.clr_err = 0;
    endtask

    task automatic shift_word(input logic [7:0] bits_msb_first_order);
        logic [7:0] b;
        b = bits_msb_first_order;
        for (int i = 7; i >= 0; i--) cyc(1, b[i], 0, 0);
    endtask

    logic exp_irq3;

    initial begin
`ifdef PRISM_SFIFO_THRESH_IRQ_EN
        exp_irq3 = 1'b1;
`else
        exp_irq3 = 1'b0;
`endif
        bus.enable = 1; bus.shift_en = 0; bus.shift_in = 0; bus.shift_dir = 0;
        bus.auto_push = 0; bus.push = 0; bus.rd_req = 0; bus.flush = 0;
        bus.clr_err = 0; bus.thresh = 3'd3;

        // Reset values
        @(negedge clk); #1;
        chk("rst_empty", bus.empty, 1);
        chk("rst_level", bus.level, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_bit_cnt", bus.bit_cnt, 0);
        chk("rst_flags", {bus.full, bus.overflow, bus.underflow, bus.irq, bus.shift_out}, 0);
        rst_n = 1; check_en = 1;
        cyc(0, 0, 0, 0);

        // MSB-first auto-push: bits 1,0,1,0,0,1,0,1
        bus.auto_push = 1; bus.shift_dir = 0;
        shift_word(8'b1010_0101);
        chk("msb_level", bus.level, 1);
        chk("msb_rd_data", bus.rd_data, 8'hA5);
        chk("msb_bit_cnt", bus.bit_cnt, 0);
        cyc(0, 0, 0, 1);

        // LSB-first, same bits: first bit lands in sr[0]
        bus.shift_dir = 1;
        shift_word(8'b1010_0101);
        chk("lsb_rd_data", bus.rd_data, 8'hA5);
        chk("lsb_shift_out", bus.shift_out, 1);
        cyc(0, 0, 0, 1);

        // Asymmetric word distinguishes the two directions
        bus.shift_dir = 0;
        shift_word(8'b0000_0011);
        chk("msb_asym", bus.rd_data, 8'h03);
        cyc(0, 0, 0, 1);
        bus.shift_dir = 1;
        shift_word(8'b0000_0011);
        chk("lsb_asym", bus.rd_data, 8'hC0);
        chk("lsb_asym_so", bus.shift_out, 0);
        cyc(0, 0, 0, 1);

        // Overflow: 5 explicit pushes of the post-shift value
        bus.auto_push = 0; bus.shift_dir = 0; bus.flush = 1;
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0);
        chk("ovf_full", bus.full, 1);
        chk("ovf_level", bus.level, 4);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_head", bus.rd_data, 8'h01);
        bus.clr_err = 1;
        cyc(0, 0, 0, 0);
        chk("ovf_clr", bus.overflow, 0);

        // Full: push + pop together
        cyc(1, 1, 1, 1);
        chk("fullpp_level", bus.level, 4);
        chk("fullpp_head", bus.rd_data, 8'h03);
        chk("fullpp_ovf", bus.overflow, 0);

        // Drain, then underflow cases
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        chk("drain_empty", bus.empty, 1);
        cyc(0, 0, 0, 1);
        chk("udf_flag", bus.underflow, 1);
        chk("udf_level", bus.level, 0);
        bus.clr_err = 1;
        cyc(0, 0, 0, 1);
        chk("udf_set_wins", bus.underflow, 1);
        bus.clr_err = 1;
        cyc(0, 0, 0, 0);
        chk("udf_clr", bus.underflow, 0);
        cyc(0, 0, 1, 1);
        chk("udfpush_flag", bus.underflow, 1);
        chk("udfpush_level", bus.level, 1);
        chk("udfpush_data", bus.rd_data, 8'h3F);

        // enable gates shift/push but not pop
        bus.enable = 0;
        cyc(1, 1, 1, 0);
        chk("en_level", bus.level, 1);
        chk("en_bit_cnt", bus.bit_cnt, 6);
        cyc(0, 0, 0, 1);
        chk("en_pop", bus.level, 0);
        bus.enable = 1;

        // Threshold irq, then flush mid-word
        bus.clr_err = 1; bus.flush = 1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("irq_lvl2", bus.irq, 0);
        cyc(0, 0, 1, 0);
        chk("irq_lvl3", bus.irq, exp_irq3);
        cyc(0, 0, 0, 1);
        chk("irq_pop", bus.irq, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
        chk("flush_pre_bc", bus.bit_cnt, 5);
        bus.flush = 1;
        cyc(0, 0, 0, 0);
        chk("flush_bc", bus.bit_cnt, 0);
        chk("flush_level", bus.level, 0);
        chk("flush_empty", bus.empty, 1);

        // Asynchronous reset mid-word with data queued
        cyc(1, 1, 1, 0);
        cyc(1, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        chk("arst_level", bus.level, 0);
        chk("arst_bit_cnt", bus.bit_cnt, 0);
        chk("arst_empty", bus.empty, 1);
        chk("arst_rd_data", bus.rd_data, 0);
        @(negedge clk); #1;
        rst_n = 1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
